// File: rtl/systolic_pkg.sv
// Shared constants and the signed clamp/truncate helper used by the systolic PE.
// Values are carried at MAXW bits, so every width used with the helper must be below 64.
package systolic_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 24;
    localparam int DEF_OW = 16;
    localparam int MAXW   = 64;

    localparam logic signed [MAXW-1:0] ONE = 1;

    typedef struct packed {
        logic signed [MAXW-1:0] val;
        logic                   clip;
    } reduce_t;

    // Reduce a sign-extended value to outW bits: clamp when sat is set, otherwise keep the low bits.
    function automatic reduce_t satReduce(input logic signed [MAXW-1:0] v,
                                          input int outW,
                                          input logic sat);
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        logic signed [MAXW-1:0] wrapped;
        reduce_t r;
        hi      = (ONE <<< (outW - 1)) - ONE;
        lo      = -hi - ONE;
        wrapped = (v <<< (MAXW - outW)) >>> (MAXW - outW);
        r.clip  = (v > hi) || (v < lo);
        r.val   = !r.clip ? v : (sat ? ((v > hi) ? hi : lo) : wrapped);
        return r;
    endfunction

endpackage

// File: rtl/systolic_pe_sat.sv
// Combinational width reducer: clamps or wraps a signed value to OUT_W bits.
// o_clip flags any value that does not fit in OUT_W bits.
module pe_sat
    import systolic_pkg::*;
#(
    parameter int IN_W  = 25,
    parameter int OUT_W = 24,
    parameter int SAT   = 1
)(
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clip
);

    logic signed [MAXW-1:0] w_ext;
    reduce_t                w_red;

    assign w_ext  = {{(MAXW-IN_W){i_val[IN_W-1]}}, i_val};
    assign w_red  = satReduce(w_ext, OUT_W, SAT != 0);
    assign o_val  = w_red.val[OUT_W-1:0];
    assign o_clip = w_red.clip;

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary systolic processing element: forwards x/w/flush one hop,
// accumulates x*w, and drops its result into a left-to-right drain chain on flush.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int AW  = DEF_AW,
    parameter int OW  = DEF_OW,
    parameter int SAT = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [DW-1:0] x_in,
    input  logic                 x_vld_in,
    input  logic signed [DW-1:0] w_in,
    input  logic                 w_vld_in,
    input  logic                 flush_left,
    input  logic                 flush_up,
    input  logic signed [OW-1:0] y_in,
    input  logic                 y_vld_in,
    output logic signed [DW-1:0] x_out,
    output logic                 x_vld_out,
    output logic signed [DW-1:0] w_out,
    output logic                 w_vld_out,
    output logic                 flush_right,
    output logic                 flush_down,
    output logic signed [OW-1:0] y_out,
    output logic                 y_vld_out,
    output logic                 ovf,
    output logic                 coll
);

    logic signed [2*DW-1:0] w_prodRaw;
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW:0]     w_sum;
    logic signed [AW-1:0]   w_accNext;
    logic signed [OW-1:0]   w_result;
    logic                   w_accClip;
    logic                   w_resClip;
    logic                   w_mac;
    logic                   w_flush;

    logic signed [AW-1:0]   r_acc;
    logic signed [DW-1:0]   r_xOut;
    logic signed [DW-1:0]   r_wOut;
    logic                   r_xVld;
    logic                   r_wVld;
    logic                   r_flush;
    logic signed [OW-1:0]   r_yOut;
    logic                   r_yVld;
    logic                   r_ovf;
    logic                   r_coll;

    assign w_mac     = x_vld_in & w_vld_in;
    assign w_flush   = flush_left | flush_up;
    assign w_prodRaw = x_in * w_in;
    assign w_prod    = w_mac ? w_prodRaw : '0;
    // One guard bit above the accumulator so the adder can never overflow before reduction.
    assign w_sum     = $signed({r_acc[AW-1], r_acc})
                     + $signed({{(AW+1-2*DW){w_prod[2*DW-1]}}, w_prod});

    pe_sat #(.IN_W(AW+1), .OUT_W(AW), .SAT(SAT)) u_accSat (
        .i_val  (w_sum),
        .o_val  (w_accNext),
        .o_clip (w_accClip)
    );

    pe_sat #(.IN_W(AW), .OUT_W(OW), .SAT(SAT)) u_resSat (
        .i_val  (w_accNext),
        .o_val  (w_result),
        .o_clip (w_resClip)
    );

    // A flush emits the acc including this cycle's product and takes the drain slot from y_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_xOut  <= '0;
            r_wOut  <= '0;
            r_xVld  <= 1'b0;
            r_wVld  <= 1'b0;
            r_flush <= 1'b0;
            r_yOut  <= '0;
            r_yVld  <= 1'b0;
            r_ovf   <= 1'b0;
            r_coll  <= 1'b0;
        end else if (en) begin
            r_xOut  <= x_in;
            r_xVld  <= x_vld_in;
            r_wOut  <= w_in;
            r_wVld  <= w_vld_in;
            r_flush <= w_flush;
            if (w_flush) begin
                r_yOut <= w_result;
                r_yVld <= 1'b1;
                r_acc  <= '0;
            end else begin
                r_yOut <= y_in;
                r_yVld <= y_vld_in;
                r_acc  <= w_accNext;
            end
            if (w_accClip || (w_flush && w_resClip))
                r_ovf <= 1'b1;
            if (w_flush && y_vld_in)
                r_coll <= 1'b1;
        end
    end

    assign x_out       = r_xOut;
    assign x_vld_out   = r_xVld;
    assign w_out       = r_wOut;
    assign w_vld_out   = r_wVld;
    assign flush_right = r_flush;
    assign flush_down  = r_flush;
    assign y_out       = r_yOut;
    assign y_vld_out   = r_yVld;
    assign ovf         = r_ovf;
    assign coll        = r_coll;

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: directed vector table, hand sequences for
// saturation and reset, then randomized traffic against an arithmetic reference model.
module tb_systolic_pe;

    localparam int DW = 8;
    localparam int AW = 24;
    localparam int OW = 16;

    typedef struct {
        bit rst;
        bit en;
        bit xv;
        int x;
        bit wv;
        int w;
        bit fl;
        bit fu;
        bit yv;
        int y;
    } stim_t;

    typedef struct {
        stim_t s;
        bit    expYv;
        int    expY;
        bit    expColl;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, en, xVldIn, wVldIn, flushLeft, flushUp, yVldIn;
    logic signed [DW-1:0] xIn, wIn;
    logic signed [OW-1:0] yIn;
    logic signed [DW-1:0] xOut, wOut;
    logic                 xVldOut, wVldOut, flushRight, flushDown, yVldOut, ovf, coll;
    logic signed [OW-1:0] yOut;

    systolic_pe #(.DW(DW), .AW(AW), .OW(OW), .SAT(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .x_in(xIn), .x_vld_in(xVldIn), .w_in(wIn), .w_vld_in(wVldIn),
        .flush_left(flushLeft), .flush_up(flushUp), .y_in(yIn), .y_vld_in(yVldIn),
        .x_out(xOut), .x_vld_out(xVldOut), .w_out(wOut), .w_vld_out(wVldOut),
        .flush_right(flushRight), .flush_down(flushDown),
        .y_out(yOut), .y_vld_out(yVldOut), .ovf(ovf), .coll(coll)
    );

    // Narrow instance used for the accumulator and result saturation case.
    logic                 sRst, sEn, sXv, sWv, sFl;
    logic signed [7:0]    sX, sW, sXOut, sWOut, sYOut;
    logic                 sXvOut, sWvOut, sFr, sFd, sYvOut, sOvf, sColl;

    systolic_pe #(.DW(8), .AW(16), .OW(8), .SAT(1)) dutSmall (
        .clk(clk), .rst(sRst), .en(sEn),
        .x_in(sX), .x_vld_in(sXv), .w_in(sW), .w_vld_in(sWv),
        .flush_left(sFl), .flush_up(1'b0), .y_in(8'sd0), .y_vld_in(1'b0),
        .x_out(sXOut), .x_vld_out(sXvOut), .w_out(sWOut), .w_vld_out(sWvOut),
        .flush_right(sFr), .flush_down(sFd),
        .y_out(sYOut), .y_vld_out(sYvOut), .ovf(sOvf), .coll(sColl)
    );

    int checks = 0;
    int errors = 0;

    longint mAcc;
    int     mX, mW, mY;
    bit     mXv, mWv, mFr, mYv, mOvf, mColl;

    function automatic bit fitsW(longint v, int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        return (v <= hi) && (v >= -hi - 1);
    endfunction

    function automatic longint satW(longint v, int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic checkVal(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advance the abstract PE state by one clock with the given inputs.
    task automatic modelStep(input stim_t s);
        longint prod, sum, res;
        if (s.rst) begin
            mAcc = 0; mX = 0; mW = 0; mY = 0;
            mXv = 0; mWv = 0; mFr = 0; mYv = 0; mOvf = 0; mColl = 0;
        end else if (s.en) begin
            prod = (s.xv && s.wv) ? longint'(s.x) * longint'(s.w) : 0;
            sum  = mAcc + prod;
            if (!fitsW(sum, AW)) mOvf = 1;
            sum = satW(sum, AW);
            mX = s.x; mXv = s.xv; mW = s.w; mWv = s.wv;
            mFr = s.fl | s.fu;
            if (mFr) begin
                if (!fitsW(sum, OW)) mOvf = 1;
                res  = satW(sum, OW);
                mY   = int'(res);
                mYv  = 1;
                mAcc = 0;
                if (s.yv) mColl = 1;
            end else begin
                mY   = s.y;
                mYv  = s.yv;
                mAcc = sum;
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        rst       = s.rst;
        en        = s.en;
        xVldIn    = s.xv;
        xIn       = DW'(s.x);
        wVldIn    = s.wv;
        wIn       = DW'(s.w);
        flushLeft = s.fl;
        flushUp   = s.fu;
        yVldIn    = s.yv;
        yIn       = OW'(s.y);
        modelStep(s);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        checkVal("x_out", int'(xOut), mX);
        checkVal("x_vld_out", xVldOut, mXv);
        checkVal("w_out", int'(wOut), mW);
        checkVal("w_vld_out", wVldOut, mWv);
        checkVal("flush_right", flushRight, mFr);
        checkVal("flush_down", flushDown, mFr);
        checkVal("y_out", int'(yOut), mY);
        checkVal("y_vld_out", yVldOut, mYv);
        checkVal("ovf", ovf, mOvf);
        checkVal("coll", coll, mColl);
    endtask

    function automatic stim_t mk(bit r, bit e, bit xv, int x, bit wv, int w,
                                 bit fl, bit fu, bit yv, int y);
        stim_t s;
        s.rst = r; s.en = e; s.xv = xv; s.x = x; s.wv = wv; s.w = w;
        s.fl = fl; s.fu = fu; s.yv = yv; s.y = y;
        return s;
    endfunction

    vec_t  vecs[$];
    stim_t st;

    initial begin
        // Directed table: {inputs} -> expected y_vld_out, y_out, coll after the edge.
        vecs.push_back('{mk(0,1,1,3,1,4,0,0,0,0),   0, 0,   0});
        vecs.push_back('{mk(0,1,1,3,1,4,0,0,0,0),   0, 0,   0});
        vecs.push_back('{mk(0,1,1,3,1,4,0,0,0,0),   0, 0,   0});
        vecs.push_back('{mk(0,1,0,0,0,0,1,0,0,0),   1, 36,  0});
        vecs.push_back('{mk(0,0,1,9,1,9,1,0,1,77),  1, 36,  0});
        vecs.push_back('{mk(0,0,1,9,1,9,1,1,1,77),  1, 36,  0});
        vecs.push_back('{mk(0,1,0,0,0,0,0,0,0,0),   0, 0,   0});
        vecs.push_back('{mk(0,1,1,2,1,5,0,0,0,0),   0, 0,   0});
        vecs.push_back('{mk(0,1,1,-2,1,5,0,1,0,0),  1, 0,   0});
        vecs.push_back('{mk(0,1,1,7,1,-3,0,0,0,0),  0, 0,   0});
        vecs.push_back('{mk(0,1,0,0,0,0,1,0,1,55),  1, -21, 1});
        vecs.push_back('{mk(0,1,0,0,0,0,0,0,1,9),   1, 9,   1});
        vecs.push_back('{mk(0,1,0,0,0,0,0,0,0,0),   0, 0,   1});
        vecs.push_back('{mk(0,1,0,0,0,0,1,0,0,0),   1, 0,   1});

        mAcc = 0; mX = 0; mW = 0; mY = 0;
        mXv = 0; mWv = 0; mFr = 0; mYv = 0; mOvf = 0; mColl = 0;
        rst = 1; en = 0; xVldIn = 0; xIn = '0; wVldIn = 0; wIn = '0;
        flushLeft = 0; flushUp = 0; yVldIn = 0; yIn = '0;
        sRst = 1; sEn = 0; sXv = 0; sX = '0; sWv = 0; sW = '0; sFl = 0;

        // Saturation on the narrow instance: 3 x 127*127 overflows a 16-bit acc, result clamps to 8 bits.
        @(posedge clk); #1;
        checkVal("small reset ovf", sOvf, 0);
        checkVal("small reset y_vld", sYvOut, 0);
        sRst = 0; sEn = 1; sXv = 1; sX = 127; sWv = 1; sW = 127;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkVal("small ovf after 2 MACs", sOvf, 0);
        checkVal("small x_out", int'(sXOut), 127);
        @(posedge clk); #1;
        checkVal("small ovf after 3 MACs", sOvf, 1);
        sXv = 0; sWv = 0; sFl = 1;
        @(posedge clk); #1;
        checkVal("small flush y_out", int'(sYOut), 127);
        checkVal("small flush y_vld", sYvOut, 1);
        checkVal("small flush_right", sFr, 1);
        sFl = 0;
        @(posedge clk); #1;
        checkVal("small y_vld pulse ends", sYvOut, 0);
        checkVal("small ovf sticky", sOvf, 1);

        // Main instance: reset then directed table.
        applyStimulus(mk(1,0,0,0,0,0,0,0,0,0));
        applyStimulus(mk(1,1,1,5,1,5,1,0,1,4));
        checkOutput();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s);
            checkOutput();
            checkVal($sformatf("vec%0d y_vld_out", i), yVldOut, vecs[i].expYv);
            checkVal($sformatf("vec%0d y_out", i), int'(yOut), vecs[i].expY);
            checkVal($sformatf("vec%0d coll", i), coll, vecs[i].expColl);
        end

        // Reset after two MACs discards the acc without a result pulse.
        applyStimulus(mk(1,0,0,0,0,0,0,0,0,0));
        applyStimulus(mk(0,1,1,5,1,6,0,0,0,0));
        applyStimulus(mk(0,1,1,5,1,6,0,0,0,0));
        applyStimulus(mk(1,1,1,5,1,6,1,1,1,3));
        checkOutput();
        checkVal("rst y_vld_out", yVldOut, 0);
        checkVal("rst x_out", int'(xOut), 0);
        checkVal("rst flush_right", flushRight, 0);
        checkVal("rst coll", coll, 0);
        applyStimulus(mk(0,1,0,0,0,0,1,0,0,0));
        checkOutput();
        checkVal("post-rst flush y_out", int'(yOut), 0);
        checkVal("post-rst flush y_vld", yVldOut, 1);

        // Randomized traffic, including stalls and rare resets.
        for (int n = 0; n < 600; n++) begin
            st.rst = ($urandom_range(99) == 0);
            st.en  = ($urandom_range(9) != 0);
            st.xv  = ($urandom_range(3) != 0);
            st.x   = int'($urandom_range(255)) - 128;
            st.wv  = ($urandom_range(3) != 0);
            st.w   = int'($urandom_range(255)) - 128;
            st.fl  = ($urandom_range(11) == 0);
            st.fu  = ($urandom_range(11) == 0);
            st.yv  = ($urandom_range(2) == 0);
            st.y   = int'($urandom_range(65535)) - 32768;
            applyStimulus(st);
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter DW, default 8, signed operand width.
REQ-002 SHALL have parameter AW, default 24, signed accumulator width; AW >= 2*DW.
REQ-003 SHALL have parameter OW, default 16, signed result width; OW <= AW.
REQ-004 SHALL have parameter SAT, default 1; 1 = saturate, 0 = wrap (two's complement).
REQ-005 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-006 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  reset
- en  in  1  array-wide advance; 0 = stall
- x_in  in  DW  signed activation from left
- x_vld_in  in  1  x_in valid
- w_in  in  DW  signed weight from above
- w_vld_in  in  1  w_in valid
- flush_left  in  1  flush token from left
- flush_up  in  1  flush token from above
- y_in  in  OW  drain-chain result from left neighbour
- y_vld_in  in  1  y_in valid
- x_out  out  DW  registered x_in
- x_vld_out  out  1  registered x_vld_in
- w_out  out  DW  registered w_in
- w_vld_out  out  1  registered w_vld_in
- flush_right  out  1  registered flush
- flush_down  out  1  registered flush
- y_out  out  OW  drain-chain result
- y_vld_out  out  1  y_out valid
- ovf  out  1  sticky overflow/clip flag
- coll  out  1  sticky drain-collision flag

Function
REQ-007 With en=0, every register SHALL hold its value, including all outputs and acc.
REQ-008 With en=1, x/w data, valids, and flush SHALL forward with exactly 1-cycle latency, independent of MAC or flush activity; flush = flush_left OR flush_up.
REQ-009 A MAC SHALL occur when en, x_vld_in and w_vld_in are all 1: product = x_in*w_in (2*DW signed, sign-extended to AW); acc <= acc + product.
REQ-010 If SAT=1, an acc sum exceeding AW range SHALL clamp to +max/-min and set ovf; if SAT=0, it SHALL wrap and set ovf.
REQ-011 On a flush cycle (en=1, flush=1), the result SHALL be acc plus that cycle's product when a MAC is valid; the result, reduced to OW, SHALL be registered to y_out with y_vld_out=1 for one cycle, and acc SHALL clear to 0.
REQ-012 AW-to-OW reduction SHALL clamp when SAT=1 and truncate when SAT=0; ovf SHALL set when the value does not fit in OW.
REQ-013 A flush with no MAC since the last flush SHALL emit y_out=0, y_vld_out=1.
REQ-014 On a non-flush cycle with en=1, the PE SHALL pass y_out<=y_in and y_vld_out<=y_vld_in (1-cycle drain shift).
REQ-015 If flush and y_vld_in=1 coincide, the local result SHALL win, y_in SHALL be dropped, and coll SHALL set.
REQ-016 ovf and coll SHALL remain set until rst.
REQ-017 The multiplier SHALL be combinational, with no pipeline stage; total MAC-to-acc latency is 1 cycle.

Reset
REQ-018 With rst=1 at a clk edge, acc, x_out, w_out, y_out SHALL be 0, and all valids, flush_right, flush_down, ovf and coll SHALL be 0; rst SHALL override en.
REQ-019 Reset mid-accumulation SHALL discard acc without emitting a result.

Structure
REQ-020 Package systolic_pkg SHALL hold default DW/AW/OW constants and the signed clamp/truncate function.
REQ-021 Sub-module pe_sat (parameterised IN_W, OUT_W, SAT; combinational reduce plus clip flag) SHALL be instantiated twice, once for the acc update and once for the result.

Verification
REQ-022 Apply x=3,w=4 valid for 3 cycles, then flush → y_out=36, y_vld_out=1 for one cycle; acc then 0.
REQ-023 With SAT=1, AW=16, apply x=127,w=127 for 3 cycles → acc clamps at 32767, ovf=1; flush with OW=8 → y_out=127.
REQ-024 Apply x=-2,w=5 valid together with flush in the same cycle, with acc=10 → y_out=0, y_vld_out=1, acc=0.
REQ-025 Hold en=0 for 4 cycles mid-stream → outputs frozen; resume → results identical to a run without the stall.
REQ-026 Flush with y_vld_in=1, y_in=55 → y_out is the local result, coll=1; the next cycle with y_vld_in=1, y_in=9 → y_out=9.
REQ-027 Assert rst after 2 MACs → all outputs 0, no y_vld_out pulse; a subsequent flush emits 0.
